// File: rtl/branch_stats_monitor_pkg.sv
// ----------------------------------------------------------------------------
// branch_stats_monitor_pkg
// Shared constants for the branch statistics monitor and its mispredict log:
//   BSM_CNT_W_DEF      default width of every statistics counter
//   BSM_LOG_DEPTH_DEF  default depth of the mispredict log FIFO
//   BSM_PC_W           width of a program counter value
// ----------------------------------------------------------------------------
package branch_stats_monitor_pkg;

   localparam int unsigned BSM_CNT_W_DEF     = 32;
   localparam int unsigned BSM_LOG_DEPTH_DEF = 4;
   localparam int unsigned BSM_PC_W          = 32;

endpackage : branch_stats_monitor_pkg

// File: rtl/branch_stats_monitor_mispredict_log_fifo.sv
// ----------------------------------------------------------------------------
// mispredict_log_fifo
// Small circular FIFO holding the PCs of mispredicted branches.
// Ports:
//   clk_i    rising-edge clock
//   rst_i    synchronous active-high reset (empties the FIFO)
//   clear_i  synchronous software clear (empties the FIFO, beats push/pop)
//   push_i   write data_i at the tail (ignored when full unless popping too)
//   pop_i    remove the head entry (ignored when empty)
//   data_i   PC to store
//   data_o   head entry, forced to 0 while empty
//   count_o  current occupancy, 0..DEPTH
//   full_o   occupancy equals DEPTH
// ----------------------------------------------------------------------------
module mispredict_log_fifo
   import branch_stats_monitor_pkg::*;
#(
   parameter int unsigned DEPTH = BSM_LOG_DEPTH_DEF
) (
   input  logic                       clk_i,
   input  logic                       rst_i,
   input  logic                       clear_i,
   input  logic                       push_i,
   input  logic                       pop_i,
   input  logic [BSM_PC_W-1:0]        data_i,
   output logic [BSM_PC_W-1:0]        data_o,
   output logic [$clog2(DEPTH):0]     count_o,
   output logic                       full_o
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);
   localparam logic [AW:0] ZERO_CNT = (AW+1)'(0);

   logic [BSM_PC_W-1:0] r_mem [DEPTH];
   logic [AW-1:0]       r_wr_ptr;
   logic [AW-1:0]       r_rd_ptr;
   logic [AW:0]         r_count;

   logic w_empty;
   logic w_full;
   logic w_pop;
   logic w_push;

   assign w_empty = (r_count == ZERO_CNT);
   assign w_full  = (r_count == FULL_CNT);
   assign w_pop   = pop_i && !w_empty;
   // A full FIFO still accepts a write when the head leaves in the same cycle.
   assign w_push  = push_i && (!w_full || w_pop);

   // Storage array: written at the tail, contents never need a reset since
   // every read is qualified by the occupancy count.
   always_ff @(posedge clk_i) begin
      if (w_push && !rst_i && !clear_i) begin
         r_mem[r_wr_ptr] <= data_i;
      end
   end

   // Pointers and occupancy; power-of-two depth lets the pointers wrap freely.
   always_ff @(posedge clk_i) begin
      if (rst_i || clear_i) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= ZERO_CNT;
      end else begin
         if (w_push) begin
            r_wr_ptr <= r_wr_ptr + AW'(1);
         end
         if (w_pop) begin
            r_rd_ptr <= r_rd_ptr + AW'(1);
         end
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + (AW+1)'(1);
            2'b01:   r_count <= r_count - (AW+1)'(1);
            default: r_count <= r_count;
         endcase
      end
   end

   assign data_o  = w_empty ? {BSM_PC_W{1'b0}} : r_mem[r_rd_ptr];
   assign count_o = r_count;
   assign full_o  = w_full;

endmodule : mispredict_log_fifo

// File: rtl/branch_stats_monitor.sv
// ----------------------------------------------------------------------------
// branch_stats_monitor
// Counts cycles, resolved branches, mispredicts and front-end flushes, and
// logs the PC of each mispredicted branch into a small FIFO for software.
// Ports:
//   clk_i, rst_i            clock, synchronous active-high reset
//   branch_valid_i          a branch resolved in EX this cycle
//   predict_i / taken_i     predicted / actual direction (1 = taken)
//   branch_pc_i             PC of the resolving branch
//   flush_i                 IF/ID flush this cycle
//   clear_i                 software clear of counters, log and overflow flag
//   log_ready_i             consumer takes the log head
//   cycle_cnt_o .. flush_cnt_o   saturating statistics counters
//   log_valid_o, log_pc_o   log head (PC is 0 while the log is empty)
//   log_count_o             log occupancy
//   log_overflow_o          sticky: a mispredict was dropped on a full log
// ----------------------------------------------------------------------------
module branch_stats_monitor
   import branch_stats_monitor_pkg::*;
#(
   parameter int unsigned CNT_W     = BSM_CNT_W_DEF,
   parameter int unsigned LOG_DEPTH = BSM_LOG_DEPTH_DEF
) (
   input  logic                        clk_i,
   input  logic                        rst_i,
   input  logic                        branch_valid_i,
   input  logic                        predict_i,
   input  logic                        taken_i,
   input  logic [BSM_PC_W-1:0]         branch_pc_i,
   input  logic                        flush_i,
   input  logic                        clear_i,
   input  logic                        log_ready_i,
   output logic [CNT_W-1:0]            cycle_cnt_o,
   output logic [CNT_W-1:0]            branch_cnt_o,
   output logic [CNT_W-1:0]            mispredict_cnt_o,
   output logic [CNT_W-1:0]            flush_cnt_o,
   output logic                        log_valid_o,
   output logic [BSM_PC_W-1:0]         log_pc_o,
   output logic [$clog2(LOG_DEPTH):0]  log_count_o,
   output logic                        log_overflow_o
);

   localparam int unsigned CW = $clog2(LOG_DEPTH) + 1;

   // Saturating increment: holds at all-ones instead of wrapping.
   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v,
                                                input logic             en);
      if (en && (v != {CNT_W{1'b1}})) begin
         return v + CNT_W'(1);
      end else begin
         return v;
      end
   endfunction

   logic [CNT_W-1:0]    r_cycle_cnt;
   logic [CNT_W-1:0]    r_branch_cnt;
   logic [CNT_W-1:0]    r_mispredict_cnt;
   logic [CNT_W-1:0]    r_flush_cnt;
   logic                r_overflow;

   logic                w_mispredict;
   logic                w_log_valid;
   logic                w_pop;
   logic                w_full;
   logic                w_drop;
   logic [CW-1:0]       w_log_count;
   logic [BSM_PC_W-1:0] w_log_pc;

   assign w_mispredict = branch_valid_i && (predict_i != taken_i);
   assign w_log_valid  = (w_log_count != CW'(0));
   assign w_pop        = w_log_valid && log_ready_i;
   // Dropped only when full and the head is not leaving this same cycle.
   assign w_drop       = w_mispredict && w_full && !w_pop;

   mispredict_log_fifo #(
      .DEPTH   (LOG_DEPTH)
   ) u_log (
      .clk_i   (clk_i),
      .rst_i   (rst_i),
      .clear_i (clear_i),
      .push_i  (w_mispredict),
      .pop_i   (w_pop),
      .data_i  (branch_pc_i),
      .data_o  (w_log_pc),
      .count_o (w_log_count),
      .full_o  (w_full)
   );

   // Statistics counters; reset and clear both discard this cycle's events.
   always_ff @(posedge clk_i) begin
      if (rst_i || clear_i) begin
         r_cycle_cnt      <= {CNT_W{1'b0}};
         r_branch_cnt     <= {CNT_W{1'b0}};
         r_mispredict_cnt <= {CNT_W{1'b0}};
         r_flush_cnt      <= {CNT_W{1'b0}};
      end else begin
         r_cycle_cnt      <= sat_inc(r_cycle_cnt, 1'b1);
         r_branch_cnt     <= sat_inc(r_branch_cnt, branch_valid_i);
         r_mispredict_cnt <= sat_inc(r_mispredict_cnt, w_mispredict);
         r_flush_cnt      <= sat_inc(r_flush_cnt, flush_i);
      end
   end

   // Sticky overflow flag, released only by reset or clear.
   always_ff @(posedge clk_i) begin
      if (rst_i || clear_i) begin
         r_overflow <= 1'b0;
      end else if (w_drop) begin
         r_overflow <= 1'b1;
      end else begin
         r_overflow <= r_overflow;
      end
   end

   assign cycle_cnt_o      = r_cycle_cnt;
   assign branch_cnt_o     = r_branch_cnt;
   assign mispredict_cnt_o = r_mispredict_cnt;
   assign flush_cnt_o      = r_flush_cnt;
   assign log_valid_o      = w_log_valid;
   assign log_pc_o         = w_log_pc;
   assign log_count_o      = w_log_count;
   assign log_overflow_o   = r_overflow;

endmodule : branch_stats_monitor

// File: tb/tb_branch_stats_monitor.sv
// ----------------------------------------------------------------------------
// tb_branch_stats_monitor
// Directed stimulus with a queue-based reference model compared every cycle,
// plus hand-computed checkpoints. A second instance with CNT_W=4 exercises
// counter saturation on the same stimulus.
// ----------------------------------------------------------------------------
module tb_branch_stats_monitor;

   localparam int DEPTH = 4;
   localparam int CW    = $clog2(DEPTH) + 1;
   localparam longint MAX32 = 64'hFFFF_FFFF;
   localparam longint MAX4  = 15;

   logic        clk = 1'b0;
   logic        rst, bv, pr, tk, fl, clr, rdy;
   logic [31:0] pc;

   logic [31:0]   cyc_o, br_o, mis_o, fl_o, lpc_o;
   logic          lv_o, ovf_o;
   logic [CW-1:0] lcnt_o;

   logic [3:0]    cyc4_o, br4_o, mis4_o, fl4_o;
   logic [31:0]   lpc4_o;
   logic          lv4_o, ovf4_o;
   logic [CW-1:0] lcnt4_o;

   always #5 clk = ~clk;

   branch_stats_monitor dut (
      .clk_i(clk), .rst_i(rst), .branch_valid_i(bv), .predict_i(pr),
      .taken_i(tk), .branch_pc_i(pc), .flush_i(fl), .clear_i(clr),
      .log_ready_i(rdy), .cycle_cnt_o(cyc_o), .branch_cnt_o(br_o),
      .mispredict_cnt_o(mis_o), .flush_cnt_o(fl_o), .log_valid_o(lv_o),
      .log_pc_o(lpc_o), .log_count_o(lcnt_o), .log_overflow_o(ovf_o));

   branch_stats_monitor #(.CNT_W(4), .LOG_DEPTH(DEPTH)) dut4 (
      .clk_i(clk), .rst_i(rst), .branch_valid_i(bv), .predict_i(pr),
      .taken_i(tk), .branch_pc_i(pc), .flush_i(fl), .clear_i(clr),
      .log_ready_i(rdy), .cycle_cnt_o(cyc4_o), .branch_cnt_o(br4_o),
      .mispredict_cnt_o(mis4_o), .flush_cnt_o(fl4_o), .log_valid_o(lv4_o),
      .log_pc_o(lpc4_o), .log_count_o(lcnt4_o), .log_overflow_o(ovf4_o));

   int n_checks = 0;
   int n_errors = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- reference model ----------------
   longint      m_cyc, m_br, m_mis, m_fl;
   longint      m4_cyc, m4_br, m4_mis, m4_fl;
   logic [31:0] m_q[$];
   bit          m_ovf = 1'b0;
   bit          started = 1'b0;

   function automatic longint sat(input longint v, input longint mx);
      return (v > mx) ? mx : v;
   endfunction

   initial begin
      m_cyc = 0; m_br = 0; m_mis = 0; m_fl = 0;
      m4_cyc = 0; m4_br = 0; m4_mis = 0; m4_fl = 0;
   end

   always @(posedge clk) begin
      bit mis;
      bit pop;
      mis = bv && (pr != tk);
      if (rst || clr) begin
         m_cyc = 0; m_br = 0; m_mis = 0; m_fl = 0;
         m4_cyc = 0; m4_br = 0; m4_mis = 0; m4_fl = 0;
         m_q.delete();
         m_ovf = 1'b0;
         if (rst) started = 1'b1;
      end else begin
         m_cyc  = sat(m_cyc + 1, MAX32);
         m_br   = sat(m_br + longint'(bv), MAX32);
         m_mis  = sat(m_mis + longint'(mis), MAX32);
         m_fl   = sat(m_fl + longint'(fl), MAX32);
         m4_cyc = sat(m4_cyc + 1, MAX4);
         m4_br  = sat(m4_br + longint'(bv), MAX4);
         m4_mis = sat(m4_mis + longint'(mis), MAX4);
         m4_fl  = sat(m4_fl + longint'(fl), MAX4);
         pop = (m_q.size() != 0) && rdy;
         if (pop) void'(m_q.pop_front());
         if (mis) begin
            if (m_q.size() < DEPTH) m_q.push_back(pc);
            else m_ovf = 1'b1;
         end
      end
      #1;
      if (started) begin
         chk("m_cycle_cnt", 64'(cyc_o), 64'(m_cyc));
         chk("m_branch_cnt", 64'(br_o), 64'(m_br));
         chk("m_mispredict_cnt", 64'(mis_o), 64'(m_mis));
         chk("m_flush_cnt", 64'(fl_o), 64'(m_fl));
         chk("m_log_count", 64'(lcnt_o), 64'(m_q.size()));
         chk("m_log_valid", 64'(lv_o), 64'(m_q.size() != 0));
         chk("m_log_pc", 64'(lpc_o), (m_q.size() != 0) ? 64'(m_q[0]) : 64'd0);
         chk("m_overflow", 64'(ovf_o), 64'(m_ovf));
         chk("m4_cycle_cnt", 64'(cyc4_o), 64'(m4_cyc));
         chk("m4_branch_cnt", 64'(br4_o), 64'(m4_br));
         chk("m4_mispredict_cnt", 64'(mis4_o), 64'(m4_mis));
         chk("m4_flush_cnt", 64'(fl4_o), 64'(m4_fl));
      end
   end

   // ---------------- stimulus ----------------
   // Apply inputs now (at a falling edge) and return at the next falling edge.
   task automatic drive(input bit v, input bit p, input bit t, input logic [31:0] a,
                        input bit f, input bit c, input bit r);
      bv = v; pr = p; tk = t; pc = a; fl = f; clr = c; rdy = r;
      @(negedge clk);
   endtask

   task automatic idle(input int n, input bit r);
      for (int i = 0; i < n; i++) drive(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, r);
   endtask

   task automatic mispredict(input logic [31:0] a, input bit r);
      drive(1'b1, 1'b1, 1'b0, a, 1'b0, 1'b0, r);
   endtask

   logic [31:0] exp_q[$];

   initial begin
      rst = 1'b1;
      bv = 1'b0; pr = 1'b0; tk = 1'b0; pc = 32'h0; fl = 1'b0; clr = 1'b0; rdy = 1'b0;
      @(negedge clk);
      idle(1, 1'b0);
      chk("rst_cycle", 64'(cyc_o), 64'd0);
      chk("rst_log_valid", 64'(lv_o), 64'd0);
      chk("rst_log_pc", 64'(lpc_o), 64'd0);
      rst = 1'b0;

      // idle counting
      idle(10, 1'b0);
      chk("idle_cycle10", 64'(cyc_o), 64'd10);
      chk("idle_branch0", 64'(br_o), 64'd0);
      chk("idle_log_valid", 64'(lv_o), 64'd0);

      // three branches, two mispredicts
      drive(1'b1, 1'b1, 1'b1, 32'h10, 1'b0, 1'b0, 1'b0);
      drive(1'b1, 1'b1, 1'b0, 32'h20, 1'b0, 1'b0, 1'b0);
      drive(1'b1, 1'b0, 1'b1, 32'h30, 1'b0, 1'b0, 1'b0);
      chk("b3_branch", 64'(br_o), 64'd3);
      chk("b3_mispredict", 64'(mis_o), 64'd2);
      chk("b3_head", 64'(lpc_o), 64'h20);
      idle(1, 1'b1);
      chk("b3_head2", 64'(lpc_o), 64'h30);
      idle(1, 1'b1);
      chk("b3_empty", 64'(lv_o), 64'd0);

      // overflow on five pushes, then drain
      for (int i = 0; i < 5; i++) mispredict(32'h4 + 32'(i) * 32'h4, 1'b0);
      chk("ovf_count", 64'(lcnt_o), 64'd4);
      chk("ovf_flag", 64'(ovf_o), 64'd1);
      exp_q = '{32'h4, 32'h8, 32'hC, 32'h10};
      foreach (exp_q[i]) begin
         chk("ovf_drain", 64'(lpc_o), 64'(exp_q[i]));
         idle(1, 1'b1);
      end
      chk("ovf_drained", 64'(lcnt_o), 64'd0);
      chk("ovf_sticky", 64'(ovf_o), 64'd1);
      drive(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 1'b0);
      chk("clr_ovf", 64'(ovf_o), 64'd0);

      // full log, simultaneous push and pop
      for (int i = 0; i < 4; i++) mispredict(32'h100 + 32'(i) * 32'h4, 1'b0);
      mispredict(32'h40, 1'b1);
      chk("full_pp_count", 64'(lcnt_o), 64'd4);
      chk("full_pp_ovf", 64'(ovf_o), 64'd0);
      exp_q = '{32'h104, 32'h108, 32'h10C, 32'h40};
      foreach (exp_q[i]) begin
         chk("full_pp_drain", 64'(lpc_o), 64'(exp_q[i]));
         idle(1, 1'b1);
      end

      // ready while empty
      idle(2, 1'b1);
      chk("empty_ready_count", 64'(lcnt_o), 64'd0);
      chk("empty_ready_pc", 64'(lpc_o), 64'd0);

      // 4-bit saturation
      drive(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 1'b0);
      for (int i = 0; i < 20; i++) drive(1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 1'b0);
      chk("sat4_flush", 64'(fl4_o), 64'd15);
      chk("sat4_cycle", 64'(cyc4_o), 64'd15);
      chk("flush32", 64'(fl_o), 64'd20);

      // clear wins over a same-cycle mispredict
      for (int i = 0; i < 5; i++) mispredict(32'h200 + 32'(i), 1'b0);
      drive(1'b1, 1'b1, 1'b0, 32'h99, 1'b1, 1'b1, 1'b0);
      chk("clr_cycle", 64'(cyc_o), 64'd0);
      chk("clr_mis", 64'(mis_o), 64'd0);
      chk("clr_flush", 64'(fl_o), 64'd0);
      chk("clr_count", 64'(lcnt_o), 64'd0);
      chk("clr_ovf2", 64'(ovf_o), 64'd0);

      // reset mid-stream discards log
      mispredict(32'h300, 1'b0);
      mispredict(32'h304, 1'b0);
      rst = 1'b1;
      mispredict(32'h308, 1'b0);
      chk("midrst_count", 64'(lcnt_o), 64'd0);
      rst = 1'b0;
      idle(1, 1'b0);
      chk("midrst_cycle1", 64'(cyc_o), 64'd1);
      idle(2, 1'b0);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule : tb_branch_stats_monitor
